// File: rtl/sram_test_sequencer.sv
// sram_test_sequencer: two-pass write/read-back memory test master for the SRAM controller.
// Pass 0 writes/checks pat(a); pass 1 writes/checks ~pat(a) over 0..LAST_ADDR.
// Optional feature macro: SRAM_SEQ_TIMEOUT_EN (ack watchdog plus o_timeout output).
module sram_test_sequencer #(
  parameter int unsigned AW        = 20,
  parameter int unsigned DW        = 8,
  parameter int unsigned LAST_ADDR = 2**AW - 1,
  parameter logic [7:0]  SEED      = 8'hA5,
  parameter int unsigned HB_BITS   = 24
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  output logic          o_req,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  input  logic          i_ack,
  input  logic [DW-1:0] i_rdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [AW-1:0] o_err_addr,
  output logic [7:0]    o_err_count,
  output logic          o_led
`ifdef SRAM_SEQ_TIMEOUT_EN
  ,
  output logic          o_timeout
`endif
);

  localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE, S_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                pass_q, pass_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [AW-1:0]       oaddr_q, oaddr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ok_q, ok_d;
  logic [AW-1:0]       err_addr_q, err_addr_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                led_q, led_d;
  logic [HB_BITS-1:0]  hb_q, hb_d;
  logic                go_done, go_fail;
  logic [DW-1:0]       exp_c;
`ifdef SRAM_SEQ_TIMEOUT_EN
  logic [15:0]         wd_q, wd_d;
  logic                to_q, to_d;
`endif

  // Test pattern for an address; the second pass uses the full-width inverse.
  function automatic logic [DW-1:0] pat_f(input logic [AW-1:0] a, input logic inv);
    logic [7:0]    p;
    logic [DW-1:0] w;
    p = a[7:0] ^ SEED ^ a[AW-1:AW-8];
    w = DW'(p);
    return inv ? ~w : w;
  endfunction

  assign exp_c = pat_f(addr_q, pass_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pass_d     = pass_q;
    req_d      = req_q;
    we_d       = we_q;
    oaddr_d    = oaddr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ok_d       = ok_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    led_d      = led_q;
    hb_d       = hb_q;
    go_done    = 1'b0;
    go_fail    = 1'b0;
`ifdef SRAM_SEQ_TIMEOUT_EN
    wd_d       = 16'd0;
    to_d       = to_q;
`endif

    if (busy_q) begin
      hb_d  = hb_q + HB_BITS'(1);
      led_d = hb_q[HB_BITS-1];
    end

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (i_start) begin
          done_d     = 1'b0;
          ok_d       = 1'b0;
          err_cnt_d  = 8'd0;
          err_addr_d = '0;
          pass_d     = 1'b0;
          addr_d     = '0;
          busy_d     = 1'b1;
          hb_d       = '0;
          led_d      = 1'b0;
`ifdef SRAM_SEQ_TIMEOUT_EN
          to_d       = 1'b0;
`endif
          state_d    = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        req_d   = 1'b1;
        we_d    = 1'b1;
        oaddr_d = addr_q;
        wdata_d = exp_c;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (i_ack) begin
          req_d = 1'b0;
          if (addr_q == LAST) begin
            addr_d  = '0;
            state_d = S_RD_REQ;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = S_WR_REQ;
          end
        end
`ifdef SRAM_SEQ_TIMEOUT_EN
        else if (wd_q == 16'hFFFE) begin
          err_addr_d = addr_q;
          err_cnt_d  = 8'hFF;
          to_d       = 1'b1;
          go_fail    = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      S_RD_REQ: begin
        req_d   = 1'b1;
        we_d    = 1'b0;
        oaddr_d = addr_q;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_ack) begin
          req_d = 1'b0;
          if (i_rdata != exp_c) begin
            if (err_cnt_q == 8'd0) err_addr_d = addr_q;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
          if (addr_q == LAST) begin
            if (!pass_q) begin
              pass_d  = 1'b1;
              addr_d  = '0;
              state_d = S_WR_REQ;
            end else if (err_cnt_d == 8'd0) begin
              go_done = 1'b1;
            end else begin
              go_fail = 1'b1;
            end
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = S_RD_REQ;
          end
        end
`ifdef SRAM_SEQ_TIMEOUT_EN
        else if (wd_q == 16'hFFFE) begin
          err_addr_d = addr_q;
          err_cnt_d  = 8'hFF;
          to_d       = 1'b1;
          go_fail    = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Common completion: LED goes steady on for pass, off for fail.
    if (go_done || go_fail) begin
      state_d = go_done ? S_DONE : S_FAIL;
      req_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      ok_d    = go_done;
      led_d   = go_done;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      pass_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      oaddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= 8'd0;
      led_q      <= 1'b0;
      hb_q       <= '0;
`ifdef SRAM_SEQ_TIMEOUT_EN
      wd_q       <= 16'd0;
      to_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      req_q      <= req_d;
      we_q       <= we_d;
      oaddr_q    <= oaddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
      led_q      <= led_d;
      hb_q       <= hb_d;
`ifdef SRAM_SEQ_TIMEOUT_EN
      wd_q       <= wd_d;
      to_q       <= to_d;
`endif
    end
  end

  assign o_req       = req_q;
  assign o_we        = we_q;
  assign o_addr      = oaddr_q;
  assign o_wdata     = wdata_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = ok_q;
  assign o_err_addr  = err_addr_q;
  assign o_err_count = err_cnt_q;
  assign o_led       = led_q;
`ifdef SRAM_SEQ_TIMEOUT_EN
  assign o_timeout   = to_q;
`endif

endmodule
